// File: rtl/lcd_link_ctrl.sv
// Sequencer/arbiter in front of the byte-wide LCD SPI engine: LCD hardware reset,
// command vs. pixel arbitration, per-frame address-window preamble and D/C hold.
module lcd_link_ctrl #(
  parameter int WIDTH       = 160,
  parameter int HEIGHT      = 128,
  parameter int RST_CYCLES  = 16,
  parameter int WAKE_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  input  logic        cmd_dc,
  input  logic [7:0]  cmd_byte,
  output logic        cmd_ready,
  input  logic        pix_valid,
  input  logic [15:0] pix_data,
  output logic        pix_ready,
  output logic        spi_start,
  output logic [7:0]  spi_data,
  input  logic        spi_new_data,
  output logic        lcd_dc,
  output logic        lcd_rst,
  output logic        init_done,
  output logic        frame_done
);

  localparam int NPIX    = WIDTH * HEIGHT;
  localparam int PIX_W   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int CNT_MAX = (RST_CYCLES > WAKE_CYCLES) ? RST_CYCLES : WAKE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [PIX_W-1:0] PIX_LAST  = PIX_W'(NPIX - 1);
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [7:0]       COL_END   = 8'(WIDTH - 1);
  localparam logic [7:0]       ROW_END   = 8'(HEIGHT - 1);
  localparam logic [3:0]       PRE_LAST  = 4'd10;

  // Handshake: valid is held by the source until the one-cycle ready pulse;
  // ready coincides with the spi_start of the first byte of that transfer.

  typedef enum logic [2:0] {
    RST_HOLD,
    RST_WAIT,
    IDLE,
    SEND,
    WAIT_DONE
  } state_t;

  typedef enum logic [1:0] {
    SEQ_CMD,
    SEQ_PRE,
    SEQ_PIX
  } seq_t;

  state_t           state;
  seq_t             seq_kind;
  logic [3:0]       seq_idx;
  logic [CNT_W-1:0] cnt;
  logic [PIX_W-1:0] pix_cnt;
  logic             win_done;
  logic [7:0]       pix_lo;

  // Address-window preamble entry {dc, byte}: CASET 0..WIDTH-1, RASET 0..HEIGHT-1, RAMWR.
  function automatic logic [8:0] pre_entry(input logic [3:0] idx);
    case (idx)
      4'd0:    pre_entry = {1'b0, 8'h2A};
      4'd4:    pre_entry = {1'b1, COL_END};
      4'd5:    pre_entry = {1'b0, 8'h2B};
      4'd9:    pre_entry = {1'b1, ROW_END};
      4'd10:   pre_entry = {1'b0, 8'h2C};
      default: pre_entry = {1'b1, 8'h00};
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RST_HOLD;
      seq_kind   <= SEQ_CMD;
      seq_idx    <= 4'd0;
      cnt        <= '0;
      pix_cnt    <= '0;
      win_done   <= 1'b0;
      pix_lo     <= 8'h00;
      spi_start  <= 1'b0;
      spi_data   <= 8'h00;
      lcd_dc     <= 1'b0;
      lcd_rst    <= 1'b0;
      cmd_ready  <= 1'b0;
      pix_ready  <= 1'b0;
      init_done  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      spi_start  <= 1'b0;
      cmd_ready  <= 1'b0;
      pix_ready  <= 1'b0;
      frame_done <= 1'b0;

      case (state)
        RST_HOLD: begin
          if (cnt == RST_LAST) begin
            cnt     <= '0;
            lcd_rst <= 1'b1;
            state   <= RST_WAIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        RST_WAIT: begin
          if (cnt == WAKE_LAST) begin
            cnt       <= '0;
            init_done <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b1;
            spi_start <= 1'b1;
            spi_data  <= cmd_byte;
            lcd_dc    <= cmd_dc;
            seq_kind  <= SEQ_CMD;
            seq_idx   <= 4'd0;
            state     <= SEND;
            // A new command opcode invalidates any window/frame in progress.
            if (!cmd_dc) begin
              win_done <= 1'b0;
              pix_cnt  <= '0;
            end
          end else if (pix_valid && !win_done) begin
            {lcd_dc, spi_data} <= pre_entry(4'd0);
            spi_start <= 1'b1;
            seq_kind  <= SEQ_PRE;
            seq_idx   <= 4'd0;
            state     <= SEND;
          end else if (pix_valid) begin
            pix_ready <= 1'b1;
            spi_start <= 1'b1;
            spi_data  <= pix_data[15:8];
            pix_lo    <= pix_data[7:0];
            lcd_dc    <= 1'b1;
            seq_kind  <= SEQ_PIX;
            seq_idx   <= 4'd0;
            state     <= SEND;
          end
        end

        SEND: begin
          state <= WAIT_DONE;
        end

        WAIT_DONE: begin
          if (spi_new_data) begin
            case (seq_kind)
              SEQ_PRE: begin
                if (seq_idx == PRE_LAST) begin
                  win_done <= 1'b1;
                  state    <= IDLE;
                end else begin
                  seq_idx            <= seq_idx + 4'd1;
                  {lcd_dc, spi_data} <= pre_entry(seq_idx + 4'd1);
                  spi_start          <= 1'b1;
                  state              <= SEND;
                end
              end
              SEQ_PIX: begin
                if (seq_idx == 4'd0) begin
                  seq_idx   <= 4'd1;
                  spi_data  <= pix_lo;
                  spi_start <= 1'b1;
                  state     <= SEND;
                end else begin
                  state <= IDLE;
                  if (pix_cnt == PIX_LAST) begin
                    pix_cnt    <= '0;
                    win_done   <= 1'b0;
                    frame_done <= 1'b1;
                  end else begin
                    pix_cnt <= pix_cnt + 1'b1;
                  end
                end
              end
              default: begin
                state <= IDLE;
              end
            endcase
          end
        end

        default: begin
          state <= RST_HOLD;
        end
      endcase
    end
  end

endmodule
